// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared funct3 constants, FSM encoding and request legality helper
package data_mem_responder_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Stores reuse the size bits of the load encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Size/alignment legality only; the range check depends on DEPTH_WORDS
    function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (f3[1:0] == 2'b11)                 bad = 1'b1;
        if (we && f3[2])                      bad = 1'b1;
        if ((f3[1:0] == 2'b01) && lo[0])      bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (lo != 2'b00)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store data replication and load extraction/extension
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select the addressed lanes and extend the loaded value according to funct3
    always_comb begin
        be        = 4'b1111;
        wdata_al  = wdata;
        rdata_ext = rword;
        rshift    = rword >> {addr_lo, 3'b000};
        rbyte     = rshift[7:0];
        rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                be        = 4'b1111;
                wdata_al  = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder with byte-lane stores
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [2:0]  WAIT_LAST = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        idle;
    logic        accept;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0] mem_rword;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        enter_legal;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle && rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = !idle;

    // With LATENCY=1 the commit edge is the accept edge, so the live inputs stand in for the latches
    assign cur_addr  = idle ? req_addr   : addr_q;
    assign cur_we    = idle ? req_we     : we_q;
    assign cur_f3    = idle ? req_funct3 : f3_q;
    assign cur_wdata = idle ? req_wdata  : wdata_q;
    assign cur_idx   = cur_addr[IDX_W+1:2];
    assign cur_err   = req_illegal(cur_we, cur_f3, cur_addr[1:0]) || (cur_addr[31:2] >= DEPTH_LIM);
    assign mem_rword = mem_q[cur_idx];

    mem_lane_align u_lane_align (
        .addr_lo   (cur_addr[1:0]),
        .funct3    (cur_f3),
        .wdata     (cur_wdata),
        .rword     (mem_rword),
        .be        (lane_be),
        .wdata_al  (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Next-state, request latching and response data selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        enter_legal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata;
                    cnt_d   = 3'd0;
                    if (cur_err) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (LATENCY == 1) begin
                        state_d     = ST_RESP;
                        enter_legal = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d     = ST_RESP;
                    enter_legal = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_legal) begin
            err_d   = 1'b0;
            rdata_d = cur_we ? 32'd0 : lane_rdata;
        end
    end

    // Control and response registers; reset drops any request in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage keeps its contents through reset; a store lands only on the edge entering RESP
    always_ff @(posedge clk) begin
        if (rst && enter_legal && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[cur_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int LAT_A = 2;
    localparam int NVEC  = 23;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [2:0]  b_req_funct3;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb_q[$];
    vec_t vecs[NVEC];
    int   b_acc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT_A)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_funct3(b_req_funct3), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Drive one request on a negedge, push its expectation, then scramble the inputs
    task automatic issue(input vec_t v);
        exp_t e;
        int   bound;
        bound = 0;
        while (!req_ready && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_wdata  = v.wdata;
        acc_cyc    = cyc;
        e.rdata    = v.exp_rdata;
        e.err      = v.exp_err;
        e.lat      = v.exp_err ? 1 : LAT_A;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
    endtask

    // Wait (bounded) for the response and compare it against the scoreboard head
    task automatic collect(input string tag);
        exp_t e;
        int   bound;
        bound = 0;
        while (!rsp_valid && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        rsp_ready = 1'b1;
        issue(v);
        collect(tag);
        @(negedge clk);
        check({tag, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
        vecs[1]  = mk(1'b0, 32'h10,  3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b1, 32'h10,  3'b010, 32'h0,        32'h0,        1'b0);
        vecs[3]  = mk(1'b1, 32'h11,  3'b000, 32'hAAAAAA80, 32'h0,        1'b0);
        vecs[4]  = mk(1'b0, 32'h11,  3'b000, 32'h0,        32'hFFFFFF80, 1'b0);
        vecs[5]  = mk(1'b0, 32'h11,  3'b100, 32'h0,        32'h00000080, 1'b0);
        vecs[6]  = mk(1'b0, 32'h10,  3'b010, 32'h0,        32'h00008000, 1'b0);
        vecs[7]  = mk(1'b0, 32'h13,  3'b001, 32'h0,        32'h0,        1'b1);
        vecs[8]  = mk(1'b0, 32'h10,  3'b010, 32'h0,        32'h00008000, 1'b0);
        vecs[9]  = mk(1'b1, 32'h100, 3'b010, 32'h55555555, 32'h0,        1'b1);
        vecs[10] = mk(1'b1, 32'h20,  3'b010, 32'h11223344, 32'h0,        1'b0);
        vecs[11] = mk(1'b1, 32'h22,  3'b001, 32'h5555BEEF, 32'h0,        1'b0);
        vecs[12] = mk(1'b0, 32'h22,  3'b001, 32'h0,        32'hFFFFBEEF, 1'b0);
        vecs[13] = mk(1'b0, 32'h22,  3'b101, 32'h0,        32'h0000BEEF, 1'b0);
        vecs[14] = mk(1'b0, 32'h20,  3'b010, 32'h0,        32'hBEEF3344, 1'b0);
        vecs[15] = mk(1'b0, 32'h20,  3'b000, 32'h0,        32'h00000044, 1'b0);
        vecs[16] = mk(1'b1, 32'h20,  3'b100, 32'h99999999, 32'h0,        1'b1);
        vecs[17] = mk(1'b0, 32'h20,  3'b011, 32'h0,        32'h0,        1'b1);
        vecs[18] = mk(1'b0, 32'h22,  3'b010, 32'h0,        32'h0,        1'b1);
        vecs[19] = mk(1'b1, 32'hFC,  3'b010, 32'hA5A5A5A5, 32'h0,        1'b0);
        vecs[20] = mk(1'b0, 32'hFC,  3'b010, 32'h0,        32'hA5A5A5A5, 1'b0);
        vecs[21] = mk(1'b0, 32'h23,  3'b000, 32'h0,        32'hFFFFFFBE, 1'b0);
        vecs[22] = mk(1'b0, 32'h20,  3'b010, 32'h0,        32'hBEEF3344, 1'b0);

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h4; b_req_funct3 = 3'b010;
        b_req_wdata = 32'd0; b_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i));
        end

        // Response held under backpressure
        rsp_ready = 1'b0;
        issue(mk(1'b0, 32'h20, 3'b010, 32'h0, 32'hBEEF3344, 1'b0));
        collect("stall");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("stall%0d_rdata", k), rsp_rdata, 32'hBEEF3344);
            check($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
            check($sformatf("stall%0d_busy", k), {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_req_ready", {31'd0, req_ready}, 32'd1);
        check("stall_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while the store is still in WAIT
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwait_busy", {31'd0, busy}, 32'd1);
        check("rstwait_in_wait", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstwait_busy_low", {31'd0, busy}, 32'd0);
        check("rstwait_req_ready", {31'd0, req_ready}, 32'd0);
        check("rstwait_rdata", rsp_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        do_req(mk(1'b0, 32'h20, 3'b010, 32'h0, 32'hBEEF3344, 1'b0), "rstwait_reload");

        // Reset while a response is pending
        rsp_ready = 1'b0;
        issue(mk(1'b0, 32'h10, 3'b010, 32'h0, 32'h00008000, 1'b0));
        collect("rstresp");
        rst = 1'b0;
        @(negedge clk);
        check("rstresp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstresp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rstresp_req_ready", {31'd0, req_ready}, 32'd1);

        // Back-to-back loads on the LATENCY=1 instance
        b_req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (b_req_valid && b_req_ready) b_acc.push_back(cyc);
            if (b_rsp_valid) check($sformatf("b2b_err%0d", k), {31'd0, b_rsp_err}, 32'd0);
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        check("b2b_accept_count", 32'(b_acc.size()), 32'd6);
        for (int k = 1; k < b_acc.size(); k++) begin
            check($sformatf("b2b_spacing%0d", k), 32'(b_acc[k] - b_acc[k-1]), 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit storage words; word index is req_addr[31:2].
REQ-002 Parameter LATENCY, default 2, legal 1..7, cycles from request accept to rsp_valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 req_valid  input  1  core presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  core accepts the response.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned, illegal or out of range.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept = req_valid && req_ready; on accept, addr, we, funct3 and wdata SHALL be latched, and the inputs are ignored afterwards.
REQ-018 Error conditions: funct3[1:0]=11; a store with funct3[2]=1; a halfword with addr[0]!=0; a word with addr[1:0]!=0; word index >= DEPTH_WORDS.
REQ-019 An erroring request SHALL go IDLE->RESP on the next edge, with rsp_err=1 and rsp_rdata=0, and SHALL NOT modify memory.
REQ-020 A legal request SHALL enter RESP with rsp_valid high exactly LATENCY cycles after the accept cycle; WAIT SHALL last LATENCY-1 cycles, and is skipped when LATENCY=1.
REQ-021 A store SHALL commit at the edge entering RESP.
REQ-022 Store lanes (little-endian): SB writes byte lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all lanes; untouched lanes SHALL be preserved.
REQ-023 Load data SHALL be registered at the edge entering RESP.
REQ-024 Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word; byte and half select follow REQ-022.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready.
REQ-026 On rsp_valid && rsp_ready, the FSM SHALL return to IDLE, with req_ready high in the following cycle; there is no same-cycle re-accept.
REQ-027 Minimum request period SHALL be LATENCY+1 cycles when rsp_ready is held high.
REQ-028 A store response SHALL assert rsp_valid with rsp_rdata=0 as a write acknowledge.
REQ-029 busy SHALL be high in WAIT and RESP.

Reset
REQ-030 While rst=0 at a rising edge: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; req_ready SHALL be 0 while rst is low.
REQ-031 Reset in WAIT SHALL abandon the request; a store not yet committed SHALL NOT be written.
REQ-032 Reset in RESP SHALL drop the pending response.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 A shared package SHALL hold the funct3 constants (F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101) and the state encoding.
REQ-035 Byte-lane enable generation and load extraction/extension SHALL live in one combinational sub-module, mem_lane_align, reusable by the core side.
REQ-036 Storage SHALL be a DEPTH_WORDS x 32 array with per-byte write enables.

Verification
REQ-037 SW 0xDEADBEEF to 0x10, then LW 0x10, with LATENCY=2 -> rsp_valid 2 cycles after each accept; rdata=0xDEADBEEF, err=0.
REQ-038 SB 0x80 to 0x11 over word 0x00000000, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0x00008000.
REQ-039 LH to 0x13 -> response 1 cycle after accept with err=1, rdata=0, memory unchanged; SW to 0x100 with DEPTH 64 -> err=1.
REQ-040 rsp_ready held low 5 cycles in RESP -> rsp_valid and rdata stable; req_ready=0 throughout, then 1 the cycle after the handshake.
REQ-041 SW 0x12345678 to 0x20, with rst low in the WAIT cycle -> outputs reset; a following LW 0x20 returns the prior contents.
REQ-042 Back-to-back loads with rsp_ready=1 and LATENCY=1 -> accepts spaced exactly 2 cycles apart.
